// File: rtl/dll_tx_scheduler.sv
`timescale 1ns/1ps
// dll_tx_scheduler
// ----------------
// Shares the single Data Link Layer TX beat slot between the DLLP source
// (Ack/Nak, UpdateFC, InitFC) and the TLP source (sequenced, LCRC appended).
// DLLPs win arbitration, but a waiting eligible TLP is guaranteed a grant
// after MAX_DLLP_BURST consecutive DLLP grants. The winner is captured into a
// one-entry registered output slot that feeds the PHY-side framer.
//
// Handshakes (all three interfaces): a transfer happens on a rising clk edge
// where valid and ready are both high. A source holds valid and payload
// stable until it sees ready. The output slot keeps tx_data_o and
// tx_is_dllp_o stable while tx_valid_o is high and tx_ready_i is low.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   dl_active_i       link is DL_Active; TLPs are only eligible when high
//   dllp_i/_valid_i   DLLP payload / offered;  dllp_ready_o = DLLP granted
//   tlp_i/_valid_i    TLP payload / offered;   tlp_ready_o  = TLP granted
//   tx_data_o         registered beat (DLLP beats are zero-extended)
//   tx_valid_o        beat valid
//   tx_is_dllp_o      beat carries a DLLP
//   tx_ready_i        framer accepts the beat
//   dllp_cnt_o        DLLPs issued (wrapping)
//   tlp_cnt_o         TLPs issued (wrapping)
module dll_tx_scheduler #(
    parameter int MAX_DLLP_BURST = 4,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dl_active_i,
    input  logic [47:0]       dllp_i,
    input  logic              dllp_valid_i,
    output logic              dllp_ready_o,
    input  logic [1195:0]     tlp_i,
    input  logic              tlp_valid_i,
    output logic              tlp_ready_o,
    output logic [1195:0]     tx_data_o,
    output logic              tx_valid_o,
    output logic              tx_is_dllp_o,
    input  logic              tx_ready_i,
    output logic [CNT_W-1:0]  dllp_cnt_o,
    output logic [CNT_W-1:0]  tlp_cnt_o
);

    localparam int              DLLP_W    = 48;
    localparam int              TLP_W     = 1196;
    localparam logic [3:0]      BURST_MAX = 4'(MAX_DLLP_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Consecutive DLLP grants made while an eligible TLP was waiting.
    logic [3:0] streak;
    logic [3:0] streak_nxt;

    logic load;
    logic tlp_elig;
    logic burst_hit;
    logic grant_dllp;
    logic grant_tlp;

    // Grant selection. The slot can take a new beat when it is empty or its
    // current beat leaves this edge, which gives back-to-back throughput.
    // Grants are suppressed during reset so both readys read 0.
    always_comb begin
        load       = !tx_valid_o || tx_ready_i;
        tlp_elig   = tlp_valid_i && dl_active_i;
        burst_hit  = tlp_elig && (streak == BURST_MAX);
        grant_dllp = !rst && load && dllp_valid_i && !burst_hit;
        grant_tlp  = !rst && load && !grant_dllp && tlp_elig;
    end

    assign dllp_ready_o = grant_dllp;
    assign tlp_ready_o  = grant_tlp;

    // Streak only counts while a TLP is actually waiting; any cycle without
    // an eligible TLP (including link down) clears it.
    always_comb begin
        streak_nxt = streak;
        if (!tlp_elig) begin
            streak_nxt = 4'd0;
        end else if (grant_tlp) begin
            streak_nxt = 4'd0;
        end else if (grant_dllp) begin
            if (streak >= BURST_MAX) begin
                streak_nxt = BURST_MAX;
            end else begin
                streak_nxt = streak + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid_o   <= 1'b0;
            tx_data_o    <= '0;
            tx_is_dllp_o <= 1'b0;
            streak       <= 4'd0;
            dllp_cnt_o   <= '0;
            tlp_cnt_o    <= '0;
        end else begin
            streak <= streak_nxt;
            if (grant_dllp) begin
                tx_valid_o   <= 1'b1;
                tx_data_o    <= {{(TLP_W-DLLP_W){1'b0}}, dllp_i};
                tx_is_dllp_o <= 1'b1;
                dllp_cnt_o   <= dllp_cnt_o + CNT_ONE;
            end else if (grant_tlp) begin
                tx_valid_o   <= 1'b1;
                tx_data_o    <= tlp_i;
                tx_is_dllp_o <= 1'b0;
                tlp_cnt_o    <= tlp_cnt_o + CNT_ONE;
            end else if (load) begin
                // Drained with nothing to replace it: data is left as-is.
                tx_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dll_tx_scheduler.sv
`timescale 1ns/1ps
module tb_dll_tx_scheduler;

    localparam int CNT_W = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              dl_active_i  = 1'b0;
    logic [47:0]       dllp_i       = '0;
    logic              dllp_valid_i = 1'b0;
    logic              dllp_ready_o;
    logic [1195:0]     tlp_i        = '0;
    logic              tlp_valid_i  = 1'b0;
    logic              tlp_ready_o;
    logic [1195:0]     tx_data_o;
    logic              tx_valid_o;
    logic              tx_is_dllp_o;
    logic              tx_ready_i   = 1'b1;
    logic [CNT_W-1:0]  dllp_cnt_o;
    logic [CNT_W-1:0]  tlp_cnt_o;

    dll_tx_scheduler #(.MAX_DLLP_BURST(4), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .dl_active_i  (dl_active_i),
        .dllp_i       (dllp_i),
        .dllp_valid_i (dllp_valid_i),
        .dllp_ready_o (dllp_ready_o),
        .tlp_i        (tlp_i),
        .tlp_valid_i  (tlp_valid_i),
        .tlp_ready_o  (tlp_ready_o),
        .tx_data_o    (tx_data_o),
        .tx_valid_o   (tx_valid_o),
        .tx_is_dllp_o (tx_is_dllp_o),
        .tx_ready_i   (tx_ready_i),
        .dllp_cnt_o   (dllp_cnt_o),
        .tlp_cnt_o    (tlp_cnt_o)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- scoreboard ----------------
    // Entry = {is_dllp, data}
    logic [1196:0] exp_q[$];

    logic [47:0]   dllp_data[32];
    logic [1195:0] tlp_data[8];
    logic [1195:0] pat_a5;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_dllp(input logic [47:0] d);
        exp_q.push_back({1'b1, 1148'b0, d});
    endtask

    task automatic push_tlp(input logic [1195:0] t);
        exp_q.push_back({1'b0, t});
    endtask

    // A beat completes on the next edge when valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && tx_valid_o && tx_ready_i) begin
            logic [1196:0] got;
            logic [1196:0] exp;
            got = {tx_is_dllp_o, tx_data_o};
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL beat_unexpected: got is_dllp=%0b data_lo=%0h expected no beat",
                         got[1196], got[63:0]);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    fails++;
                    $display("FAIL beat: got is_dllp=%0b data_lo=%0h expected is_dllp=%0b data_lo=%0h",
                             got[1196], got[63:0], exp[1196], exp[63:0]);
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_dut();
        rst          = 1'b1;
        dllp_valid_i = 1'b0;
        tlp_valid_i  = 1'b0;
        tx_ready_i   = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [1195:0] rand_tlp();
        logic [1215:0] t;
        t = '0;
        for (int i = 0; i < 38; i++) t = {t[1183:0], 32'($urandom())};
        return t[1195:0];
    endfunction

    typedef struct {
        logic dla;
        logic dv;
        logic tv;
        logic exp_dr;
        logic exp_tr;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1199:0] a5_wide;
        int di;
        int ti;

        a5_wide = {150{8'hA5}};
        pat_a5  = a5_wide[1195:0];
        for (int k = 0; k < 32; k++) dllp_data[k] = {16'($urandom_range(0, 65535)), 32'($urandom())};
        for (int k = 0; k < 8; k++) tlp_data[k] = rand_tlp();

        //            dla   dv    tv    dr    tr
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        // ---- reset with both sources offering ----
        rst          = 1'b1;
        dl_active_i  = 1'b1;
        dllp_i       = dllp_data[0];
        tlp_i        = tlp_data[0];
        dllp_valid_i = 1'b1;
        tlp_valid_i  = 1'b1;
        tx_ready_i   = 1'b1;
        tick();
        tick();
        check("rst_tx_valid", 64'(tx_valid_o), 64'd0);
        check("rst_is_dllp", 64'(tx_is_dllp_o), 64'd0);
        check("rst_data_zero", 64'(tx_data_o == '0), 64'd1);
        check("rst_dllp_ready", 64'(dllp_ready_o), 64'd0);
        check("rst_tlp_ready", 64'(tlp_ready_o), 64'd0);
        check("rst_dllp_cnt", 64'(dllp_cnt_o), 64'd0);
        check("rst_tlp_cnt", 64'(tlp_cnt_o), 64'd0);

        // ---- grant table from idle (empty slot, streak 0), combinational ----
        dllp_valid_i = 1'b0;
        tlp_valid_i  = 1'b0;
        rst          = 1'b0;
        for (int v = 0; v < 6; v++) begin
            dl_active_i  = vecs[v].dla;
            dllp_valid_i = vecs[v].dv;
            tlp_valid_i  = vecs[v].tv;
            #1;
            check($sformatf("vec%0d_dllp_ready", v), 64'(dllp_ready_o), 64'(vecs[v].exp_dr));
            check($sformatf("vec%0d_tlp_ready", v), 64'(tlp_ready_o), 64'(vecs[v].exp_tr));
        end
        dllp_valid_i = 1'b0;
        tlp_valid_i  = 1'b0;

        // ---- first beat after release ----
        rst          = 1'b1;
        dl_active_i  = 1'b1;
        dllp_valid_i = 1'b1;
        tlp_valid_i  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rel_dllp_ready", 64'(dllp_ready_o), 64'd1);
        check("rel_tlp_ready", 64'(tlp_ready_o), 64'd0);
        push_dllp(dllp_data[0]);
        tick();
        dllp_valid_i = 1'b0;
        tlp_valid_i  = 1'b0;
        check("rel_tx_valid", 64'(tx_valid_o), 64'd1);
        check("rel_is_dllp", 64'(tx_is_dllp_o), 64'd1);
        check("rel_upper_zero", 64'(tx_data_o[1195:48] == '0), 64'd1);
        tick();

        // ---- priority and burst limit: D,D,D,D,T,D,D,D,D,T ----
        rst_dut();
        dl_active_i = 1'b1;
        tx_ready_i  = 1'b1;
        di = 0;
        ti = 0;
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) begin
                push_tlp(tlp_data[ti]);
                ti++;
            end else begin
                push_dllp(dllp_data[di]);
                di++;
            end
        end
        di = 0;
        ti = 0;
        for (int c = 0; c < 10; c++) begin
            dllp_i       = dllp_data[di];
            tlp_i        = tlp_data[ti];
            dllp_valid_i = 1'b1;
            tlp_valid_i  = 1'b1;
            #1;
            if (dllp_ready_o) di++;
            if (tlp_ready_o) ti++;
            tick();
        end
        dllp_valid_i = 1'b0;
        tlp_valid_i  = 1'b0;
        check("burst_dllp_cnt", 64'(dllp_cnt_o), 64'd8);
        check("burst_tlp_cnt", 64'(tlp_cnt_o), 64'd2);
        tick();

        // ---- backpressure ----
        rst_dut();
        dl_active_i = 1'b1;
        tx_ready_i  = 1'b0;
        tlp_i       = pat_a5;
        tlp_valid_i = 1'b1;
        #1;
        check("bp_tlp_grant", 64'(tlp_ready_o), 64'd1);
        push_tlp(pat_a5);
        tick();
        tlp_i        = tlp_data[0];
        dllp_i       = dllp_data[0];
        dllp_valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_hold_valid", 64'(tx_valid_o), 64'd1);
            check("bp_hold_data", 64'(tx_data_o == pat_a5), 64'd1);
            check("bp_hold_is_dllp", 64'(tx_is_dllp_o), 64'd0);
            check("bp_hold_readys", 64'({dllp_ready_o, tlp_ready_o}), 64'd0);
            tick();
        end
        tx_ready_i = 1'b1;
        #1;
        check("bp_release_dllp_ready", 64'(dllp_ready_o), 64'd1);
        push_dllp(dllp_data[0]);
        tick();
        dllp_valid_i = 1'b0;
        check("bp_no_bubble_valid", 64'(tx_valid_o), 64'd1);
        check("bp_no_bubble_is_dllp", 64'(tx_is_dllp_o), 64'd1);
        #1;
        check("bp_tlp_next", 64'(tlp_ready_o), 64'd1);
        push_tlp(tlp_data[0]);
        tick();
        tlp_valid_i = 1'b0;
        tick();

        // ---- link gating ----
        rst_dut();
        dl_active_i = 1'b0;
        tx_ready_i  = 1'b1;
        tlp_i       = tlp_data[1];
        tlp_valid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("gate_tlp_ready", 64'(tlp_ready_o), 64'd0);
            tick();
            check("gate_tx_valid", 64'(tx_valid_o), 64'd0);
        end
        dllp_i       = dllp_data[1];
        dllp_valid_i = 1'b1;
        #1;
        check("gate_dllp_ready", 64'(dllp_ready_o), 64'd1);
        push_dllp(dllp_data[1]);
        tick();
        dllp_valid_i = 1'b0;
        check("gate_dllp_beat", 64'({tx_valid_o, tx_is_dllp_o}), 64'd3);
        #1;
        check("gate_tlp_still_blocked", 64'(tlp_ready_o), 64'd0);
        dl_active_i = 1'b1;
        #1;
        check("gate_tlp_ready_up", 64'(tlp_ready_o), 64'd1);
        push_tlp(tlp_data[1]);
        tick();
        tlp_valid_i = 1'b0;
        check("gate_tlp_beat", 64'({tx_valid_o, tx_is_dllp_o}), 64'd2);
        tick();

        // ---- link drops while a TLP is held ----
        rst_dut();
        dl_active_i = 1'b1;
        tx_ready_i  = 1'b0;
        tlp_i       = tlp_data[2];
        tlp_valid_i = 1'b1;
        #1;
        check("drop_tlp_grant", 64'(tlp_ready_o), 64'd1);
        push_tlp(tlp_data[2]);
        tick();
        tlp_i = tlp_data[3];
        for (int c = 0; c < 2; c++) begin
            #1;
            check("drop_hold_ready", 64'(tlp_ready_o), 64'd0);
            tick();
        end
        dl_active_i = 1'b0;
        tick();
        check("drop_streak", 64'(dut.streak), 64'd0);
        check("drop_still_held", 64'(tx_valid_o), 64'd1);
        tx_ready_i = 1'b1;
        #1;
        check("drop_no_new_tlp", 64'(tlp_ready_o), 64'd0);
        tick();
        check("drop_drained", 64'(tx_valid_o), 64'd0);
        #1;
        check("drop_no_new_tlp2", 64'(tlp_ready_o), 64'd0);
        check("drop_tlp_cnt", 64'(tlp_cnt_o), 64'd1);
        tlp_valid_i = 1'b0;
        dl_active_i = 1'b1;
        tick();

        // ---- counter wrap and reset mid-hold ----
        rst_dut();
        dl_active_i  = 1'b1;
        tx_ready_i   = 1'b1;
        dllp_valid_i = 1'b1;
        for (int k = 0; k < 17; k++) begin
            dllp_i = dllp_data[k];
            #1;
            check("wrap_dllp_ready", 64'(dllp_ready_o), 64'd1);
            push_dllp(dllp_data[k]);
            tick();
        end
        tx_ready_i = 1'b0;
        dllp_i     = dllp_data[17];
        check("wrap_dllp_cnt", 64'(dllp_cnt_o), 64'd1);
        #1;
        check("wrap_hold_ready", 64'(dllp_ready_o), 64'd0);
        rst = 1'b1;
        void'(exp_q.pop_back());
        #1;
        check("midrst_dllp_ready", 64'(dllp_ready_o), 64'd0);
        tick();
        check("midrst_tx_valid", 64'(tx_valid_o), 64'd0);
        check("midrst_dllp_cnt", 64'(dllp_cnt_o), 64'd0);
        check("midrst_tlp_cnt", 64'(tlp_cnt_o), 64'd0);
        rst          = 1'b0;
        dllp_valid_i = 1'b0;
        tx_ready_i   = 1'b1;
        tick();
        tick();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dll_tx_scheduler.md
Name: dll_tx_scheduler

Overview:
Registered scheduler for the Data Link Layer transmit path. It shares the single TX beat slot between the DLLP source (Ack/Nak, UpdateFC, InitFC) and the TLP source, which delivers sequenced and LCRC-appended TLPs. DLLPs have priority, with a bounded-starvation rule for TLPs. The output is a one-entry registered slot with a valid/ready handshake to the PHY-side framer. The block sits between the DLL TX sources and the framer.

Parameters:
MAX_DLLP_BURST, 4, max consecutive DLLP grants while an eligible TLP waits; legal range 1..15.
CNT_W, 16, width of the statistics counters.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
dl_active_i  input  1  DL_Active state; when low, TLPs are ineligible and DLLPs are still allowed
dllp_i  input  48  DLLP payload
dllp_valid_i  input  1  DLLP offered
dllp_ready_o  output  1  DLLP accepted this cycle
tlp_i  input  1196  TLP payload
tlp_valid_i  input  1  TLP offered
tlp_ready_o  output  1  TLP accepted this cycle
tx_data_o  output  1196  registered beat to framer
tx_valid_o  output  1  beat valid
tx_is_dllp_o  output  1  beat is a DLLP
tx_ready_i  input  1  framer accepts beat
dllp_cnt_o  output  CNT_W  DLLPs issued; wraps
tlp_cnt_o  output  CNT_W  TLPs issued; wraps

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All state changes happen on the rising edge of clk.
- Reset values: tx_valid_o=0, tx_data_o=0, tx_is_dllp_o=0, streak=0, dllp_cnt_o=0, tlp_cnt_o=0. dllp_ready_o and tlp_ready_o are 0 while rst=1.
- Reset mid-operation: any beat held in the slot is dropped, with no completion.
- Slot load enable: load = !tx_valid_o || tx_ready_i. This gives back-to-back beats at full throughput.
- TLP eligibility: tlp_elig = tlp_valid_i && dl_active_i.
- Grant selection, combinational, only when load=1:
  - dllp_valid_i && !(tlp_elig && streak==MAX_DLLP_BURST) -> grant the DLLP.
  - Otherwise, tlp_elig -> grant the TLP.
  - Otherwise, no grant.
- Ready outputs: dllp_ready_o / tlp_ready_o equal the respective grant. At most one is high in any cycle. The ready outputs never depend on the source's own valid beyond the grant equation.
- Load: on a grant, the next cycle has tx_valid_o=1.
  - DLLP grant: tx_data_o[47:0]=dllp_i, tx_data_o[1195:48]=0, tx_is_dllp_o=1.
  - TLP grant: tx_data_o=tlp_i, tx_is_dllp_o=0.
  - Latency from acceptance to valid output is 1 cycle.
- Drain without new grant: load=1 with no grant clears tx_valid_o the next cycle. tx_data_o holds its old value.
- Hold: while tx_valid_o && !tx_ready_i, tx_data_o and tx_is_dllp_o stay stable, and both ready outputs stay 0.
- Streak counter (4 bits):
  - On a DLLP grant with tlp_elig=1: streak = min(streak+1, MAX_DLLP_BURST).
  - On a TLP grant: streak = 0.
  - On any cycle with tlp_elig=0: streak = 0.
  - Otherwise: hold.
- Result of the streak rule: after MAX_DLLP_BURST consecutive DLLPs against a waiting TLP, exactly one TLP is issued, then DLLP priority resumes.
- dl_active_i falling while a TLP is held in the slot: the beat completes normally, with no retraction. No further TLP grants are made.
- Statistics: dllp_cnt_o / tlp_cnt_o increment by 1 on each respective grant. They wrap from 2^CNT_W-1 to 0.
- Source assumption: the sources must hold valid and data stable until ready. The block does not check this.

Test Plan:
1. Reset / idle: rst=1 for 2 cycles with both valids high -> all outputs 0, both readys 0. After release with dl_active_i=1 -> dllp_ready_o=1 on the first cycle, tx_valid_o=1 and tx_is_dllp_o=1 on the next cycle, tx_data_o[1195:48]=0.
2. Priority and burst limit: MAX_DLLP_BURST=4, continuous DLLPs and TLPs, tx_ready_i=1 -> issue order D,D,D,D,T,D,D,D,D,T. dllp_cnt_o=8, tlp_cnt_o=2 after 10 beats.
3. Backpressure: load a TLP with tlp_i=pattern 0xA5.., hold tx_ready_i=0 for 5 cycles -> tx_data_o stable, readys 0. Raise tx_ready_i -> the next granted beat appears the cycle after, with no bubble.
4. Link gating: dl_active_i=0, TLP only -> no grant, tx_valid_o=0. A DLLP offered -> issued. Set dl_active_i=1 -> TLP issued after 1 cycle.
5. dl_active_i drops while a TLP is held with tx_ready_i=0 -> the TLP still completes when tx_ready_i=1. The next waiting TLP is not granted. streak=0.
6. Counter wrap (CNT_W=4): issue 17 DLLPs -> dllp_cnt_o=1. Assert rst mid-hold -> tx_valid_o=0 on the next cycle and both counters are 0.
